// File: rtl/blocking_caveat_pkg.sv
// Shared definitions for the blocking_caveat checker: FSM encoding, golden
// function and parameter limits.
package blocking_caveat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int LAT_MAX    = 8;
  localparam int SETTLE_MAX = 15;

  function automatic logic exp_d(input logic a, input logic b, input logic c);
    return (a | b) & c;
  endfunction

endpackage

// File: rtl/blocking_caveat_checker_delay_line.sv
// LAT-deep shift register carrying {valid,a,b,c,d_exp}; synchronous clear,
// asynchronous active-low reset, wire-through when LAT=0.
module checker_delay_line #(
  parameter int LAT = 0,
  parameter int W   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (LAT == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, clr};
    assign dout = din;
  end else begin : g_pipe
    logic [W-1:0] line_p [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < LAT; i++) line_p[i] <= '0;
      end else if (clr) begin
        for (int i = 0; i < LAT; i++) line_p[i] <= '0;
      end else begin
        line_p[0] <= din;
        for (int i = 1; i < LAT; i++) line_p[i] <= line_p[i-1];
      end
    end

    assign dout = line_p[LAT-1];
  end

endmodule

// File: rtl/blocking_caveat_checker.sv
// Self-checking monitor for blocking_caveat: compares d against (a|b)&c delayed
// by LAT cycles. Define CHECKER_COV_EN to add cov_mask and require full coverage for pass.
module blocking_caveat_checker
  import blocking_caveat_pkg::*;
#(
  parameter int LAT    = 0,
  parameter int CNT_W  = 16,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [2:0]       first_err_vec
`ifdef CHECKER_COV_EN
  ,
  output logic [7:0]       cov_mask
`endif
);

  localparam int SW = $clog2(SETTLE_MAX + 1);
  localparam int LW = 5;

  state_t           state, state_nxt;
  logic [SW-1:0]    settle_cnt;
  logic             start_acc;
  logic             vld_p0, dexp_p0;
  logic [2:0]       abc_p0;
  logic [LW-1:0]    line_pd;
  logic             vld_pd, dexp_pd;
  logic [2:0]       abc_pd;
  logic             cmp, mism, pass_cond;
  logic [CNT_W-1:0] err_nxt, smp_nxt;
`ifdef CHECKER_COV_EN
  logic [7:0]       cov_nxt;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign busy      = (state == ST_SETTLE) || (state == ST_CHECK);
  assign done      = (state == ST_DONE);
  // A new run can only be armed from a quiescent state; start mid-run is dropped.
  assign start_acc = start && ((state == ST_IDLE) || (state == ST_DONE));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_nxt = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (stop)                               state_nxt = ST_DONE;
        else if (settle_cnt == SW'(SETTLE - 1)) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (stop) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= (state == ST_SETTLE) ? settle_cnt + SW'(1) : '0;
    end
  end

  // Stage p0: current sample and its golden expectation enter the delay line
  assign vld_p0  = busy;
  assign abc_p0  = {a, b, c};
  assign dexp_p0 = exp_d(a, b, c);

  checker_delay_line #(
    .LAT (LAT),
    .W   (LW)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_acc),
    .din   ({vld_p0, abc_p0, dexp_p0}),
    .dout  (line_pd)
  );

  // Stage pd: expectation aligned with the DUT output d
  assign vld_pd  = line_pd[4];
  assign abc_pd  = line_pd[3:1];
  assign dexp_pd = line_pd[0];

  always_comb begin
    cmp     = (state == ST_CHECK) && vld_pd;
    mism    = cmp && (d != dexp_pd);
    err_nxt = mism ? sat_inc(err_cnt) : err_cnt;
    smp_nxt = cmp ? sat_inc(sample_cnt) : sample_cnt;
`ifdef CHECKER_COV_EN
    cov_nxt   = cmp ? (cov_mask | (8'd1 << abc_pd)) : cov_mask;
    pass_cond = (err_nxt == '0) && (smp_nxt != '0) && (cov_nxt == 8'hFF);
`else
    pass_cond = (err_nxt == '0) && (smp_nxt != '0);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt       <= '0;
      sample_cnt    <= '0;
      fail          <= 1'b0;
      first_err_idx <= '0;
      first_err_vec <= '0;
      pass          <= 1'b0;
`ifdef CHECKER_COV_EN
      cov_mask      <= '0;
`endif
    end else if (start_acc) begin
      err_cnt       <= '0;
      sample_cnt    <= '0;
      fail          <= 1'b0;
      first_err_idx <= '0;
      first_err_vec <= '0;
      pass          <= 1'b0;
`ifdef CHECKER_COV_EN
      cov_mask      <= '0;
`endif
    end else begin
      err_cnt    <= err_nxt;
      sample_cnt <= smp_nxt;
      if (mism && !fail) begin
        fail          <= 1'b1;
        first_err_idx <= sample_cnt;
        first_err_vec <= abc_pd;
      end
`ifdef CHECKER_COV_EN
      cov_mask <= cov_nxt;
`endif
      // Verdict is latched on DONE entry using the final cycle's counts.
      if (state_nxt == ST_DONE) pass <= (state == ST_DONE) ? pass : pass_cond;
      else                      pass <= 1'b0;
    end
  end

endmodule

// File: tb/tb_blocking_caveat_checker.sv
// Scoreboard bench: four checker instances with different LAT/SETTLE/CNT_W watch
// modelled DUTs; expected run statistics are derived from the stimulus tables.
`timescale 1ns/1ps
module tb_blocking_caveat_checker;

  localparam int NI = 4;
  localparam int LATS [NI] = '{0, 2, 1, 0};
  localparam int SETS [NI] = '{0, 3, 0, 0};
  localparam int CWS  [NI] = '{16, 16, 16, 4};
  localparam int DLAT [NI] = '{0, 2, 2, 0};  // latency of the modelled DUT feeding d
  localparam int MAXL = 64;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0;
  logic [NI-1:0] d_vec = '0;
  logic [NI-1:0] busy, done, pass, fail;
  logic [15:0] err_cnt [NI];
  logic [15:0] sample_cnt [NI];
  logic [15:0] first_err_idx [NI];
  logic [2:0]  first_err_vec [NI];
  logic [7:0]  cov_mask [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int CW = CWS[g];
    logic [CW-1:0] e, s, f;
    blocking_caveat_checker #(
      .LAT    (LATS[g]),
      .CNT_W  (CW),
      .SETTLE (SETS[g])
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .stop          (stop),
      .a             (a),
      .b             (b),
      .c             (c),
      .d             (d_vec[g]),
      .busy          (busy[g]),
      .done          (done[g]),
      .pass          (pass[g]),
      .fail          (fail[g]),
      .err_cnt       (e),
      .sample_cnt    (s),
      .first_err_idx (f),
      .first_err_vec (first_err_vec[g])
`ifdef CHECKER_COV_EN
      ,
      .cov_mask      (cov_mask[g])
`endif
    );
    assign err_cnt[g]       = 16'(e);
    assign sample_cnt[g]    = 16'(s);
    assign first_err_idx[g] = 16'(f);
`ifndef CHECKER_COV_EN
    assign cov_mask[g] = 8'h00;
`endif
  end

  typedef struct {
    int         smp;
    int         err;
    int         idx;
    logic [2:0] vec;
    logic       fl;
    logic       ps;
    logic [7:0] cov;
  } res_t;

  res_t sb [$];
  int checks = 0;
  int failures = 0;
  logic [2:0]    abcs  [MAXL+1];  // [0] = start cycle, [k+1] = run cycle k
  logic [NI-1:0] flips [MAXL+1];
  logic [2:0] h1 = '0, h2 = '0;

  function automatic logic ref_d(input logic [2:0] v);
    return (v[2] | v[1]) & v[0];
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [NI-1:0] fl, input logic st, input logic sp);
    {a, b, c} = v;
    start = st;
    stop  = sp;
    for (int i = 0; i < NI; i++) d_vec[i] = ref_d((DLAT[i] == 2) ? h2 : v) ^ fl[i];
    @(posedge clk);
    #1;
    h2 = h1;
    h1 = v;
  endtask

  task automatic idle(input int n, input bit rand_stop);
    for (int i = 0; i < n; i++)
      drive(3'($urandom), '0, 1'b0, rand_stop ? 1'($urandom_range(1, 0)) : 1'b0);
  endtask

  // pat: 0 random, 1 a/b/c toggling every 1/5/10 cycles, 2 random with c=0.
  // fm: 0 clean, 1 single error at k=5 on {1,0,1}, 2 errors in k<3, 3 always wrong, 4 sparse random.
  task automatic gen(input int len, input int pat, input int fm);
    for (int j = 0; j <= len; j++) begin
      case (pat)
        1:       abcs[j] = {1'(j % 2), 1'((j / 5) % 2), 1'((j / 10) % 2)};
        2:       abcs[j] = {2'($urandom), 1'b0};
        default: abcs[j] = 3'($urandom);
      endcase
      flips[j] = '0;
      if (j > 0) begin
        case (fm)
          1: if (j - 1 == 5) begin flips[j] = '1; abcs[j] = 3'b101; end
          2: if (j - 1 < 3) flips[j] = '1;
          3: flips[j] = '1;
          4: for (int i = 0; i < NI; i++) flips[j][i] = ($urandom_range(7, 0) == 0);
          default: flips[j] = '0;
        endcase
      end
    end
  endtask

  task automatic push_expect(input int len);
    for (int i = 0; i < NI; i++) begin
      res_t r;
      int maxv;
      logic [2:0] v;
      logic dd;
      r.smp = 0; r.err = 0; r.idx = 0; r.vec = '0; r.fl = 1'b0; r.ps = 1'b0; r.cov = '0;
      maxv = (1 << CWS[i]) - 1;
      for (int k = 0; k < len; k++) begin
        if (k >= SETS[i] && k >= LATS[i]) begin
          v  = abcs[k + 1 - LATS[i]];
          dd = ref_d(abcs[k + 1 - DLAT[i]]) ^ flips[k + 1][i];
          if (dd != ref_d(v)) begin
            if (!r.fl) begin r.fl = 1'b1; r.idx = r.smp; r.vec = v; end
            if (r.err < maxv) r.err++;
          end
          if (r.smp < maxv) r.smp++;
          r.cov[v] = 1'b1;
        end
      end
`ifdef CHECKER_COV_EN
      r.ps = (r.err == 0) && (r.smp != 0) && (r.cov == 8'hFF);
`else
      r.ps = (r.err == 0) && (r.smp != 0);
`endif
      sb.push_back(r);
    end
  endtask

  task automatic run(input int len, input bit extra_start);
    int xs;
    push_expect(len);
    xs = (extra_start && len >= 3) ? $urandom_range(len - 2, 1) : -1;
    drive(abcs[0], '0, 1'b1, 1'($urandom_range(1, 0)));
    check("busy after start", int'(busy), (1 << NI) - 1);
    check("done after start", int'(done), 0);
    for (int k = 0; k < len; k++)
      drive(abcs[k + 1], flips[k + 1], 1'(k == xs), 1'(k == len - 1));
    idle(3, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      int sum;
      sum = int'(busy[i]) + int'(done[i]) + int'(pass[i]) + int'(fail[i]) + int'(err_cnt[i]) +
            int'(sample_cnt[i]) + int'(first_err_idx[i]) + int'(first_err_vec[i]) + int'(cov_mask[i]);
      check($sformatf("inst%0d %s outputs", i, tag), sum, 0);
    end
  endtask

  // Monitor: on each DONE entry pop one expected record per instance.
  initial begin
    logic prev;
    res_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev = 1'b0;
      else begin
        if (done[0] && !prev) begin
          for (int i = 0; i < NI; i++) begin
            if (sb.size() == 0) begin
              check($sformatf("inst%0d unexpected done", i), 1, 0);
            end else begin
              e = sb.pop_front();
              check($sformatf("inst%0d done", i), int'(done[i]), 1);
              check($sformatf("inst%0d sample_cnt", i), int'(sample_cnt[i]), e.smp);
              check($sformatf("inst%0d err_cnt", i), int'(err_cnt[i]), e.err);
              check($sformatf("inst%0d first_err_idx", i), int'(first_err_idx[i]), e.idx);
              check($sformatf("inst%0d first_err_vec", i), int'(first_err_vec[i]), int'(e.vec));
              check($sformatf("inst%0d fail", i), int'(fail[i]), int'(e.fl));
              check($sformatf("inst%0d pass", i), int'(pass[i]), int'(e.ps));
`ifdef CHECKER_COV_EN
              check($sformatf("inst%0d cov_mask", i), int'(cov_mask[i]), int'(e.cov));
`endif
            end
          end
        end
        prev = done[0];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle(3, 1'b0);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(4, 1'b1);
    check("busy with stop in idle", int'(busy), 0);
    check("done with stop in idle", int'(done), 0);

    gen(40, 1, 0); run(40, 1'b0);
    gen(30, 0, 1); run(30, 1'b0);
    gen(20, 0, 2); run(20, 1'b0);
    gen(20, 0, 3); run(20, 1'b0);
    gen(2, 0, 0);  run(2, 1'b0);
    gen(32, 0, 0); run(32, 1'b1);

    // Asynchronous reset in the middle of a run.
    gen(30, 0, 0);
    drive(abcs[0], '0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) drive(abcs[k + 1], '0, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1 check_all_zero("mid-run reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2, 1'b0);

    gen(40, 2, 0); run(40, 1'b1);
    for (int r = 0; r < 12; r++) begin
      int len;
      len = $urandom_range(60, 1);
      gen(len, 0, ($urandom_range(1, 0) == 1) ? 4 : 0);
      run(len, 1'($urandom_range(1, 0)));
    end

    idle(5, 1'b0);
    check("scoreboard drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
